// File: rtl/port_wr_pkg.sv
// Shared definitions for the port write arbiter: FSM encoding and default widths.
package port_wr_pkg;

  localparam int ADDR_W_DEF = 3;
  localparam int DATA_W_DEF = 8;
  localparam int WR_CNT_W   = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETUP   = 2'd1,
    ST_STROBE  = 2'd2,
    ST_RECOVER = 2'd3
  } wr_state_e;

endpackage

// File: rtl/port_wr_arb_rr_pick2.sv
// Two-input round-robin picker: the requester not granted last wins a tie.
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant
);

  always_comb begin
    grant_valid = req0 | req1;
    if (req0 && req1) begin
      grant = ~last_grant;
    end else begin
      grant = req1;
    end
  end

endmodule

// File: rtl/port_wr_arb.sv
// Arbitrates two write requesters onto a port write decoder using a fixed
// SETUP / STROBE / RECOVER sequence; every output comes straight from a flop.
module port_wr_arb
  import port_wr_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                req0,
  input  logic [ADDR_W-1:0]   addr0,
  input  logic [DATA_W-1:0]   data0,
  output logic                ack0,
  input  logic                req1,
  input  logic [ADDR_W-1:0]   addr1,
  input  logic [DATA_W-1:0]   data1,
  output logic                ack1,
  output logic                dec_en_n,
  output logic                dec_wr_strobe,
  output logic [ADDR_W-1:0]   dec_sel,
  output logic [DATA_W-1:0]   dec_data,
  output logic                busy,
  output logic [WR_CNT_W-1:0] wr_count
);

  wr_state_e             state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  winner_q, winner_d;
  logic                  en_n_q, en_n_d;
  logic                  strobe_q, strobe_d;
  logic                  ack0_q, ack0_d;
  logic                  ack1_q, ack1_d;
  logic                  busy_q, busy_d;
  logic [ADDR_W-1:0]     sel_q, sel_d;
  logic [DATA_W-1:0]     data_q, data_d;
  logic [WR_CNT_W-1:0]   cnt_q, cnt_d;

  logic                  grant_valid;
  logic                  grant;

  rr_pick2 u_pick (
    .req0        (req0),
    .req1        (req1),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant       (grant)
  );

  // The *_d values are the outputs for the state being entered, so each
  // output flop already holds its value for the current state.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    winner_d     = winner_q;
    en_n_d       = 1'b1;
    strobe_d     = 1'b0;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    sel_d        = sel_q;
    data_d       = data_q;
    cnt_d        = cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          state_d      = ST_SETUP;
          en_n_d       = 1'b0;
          winner_d     = grant;
          last_grant_d = grant;
          sel_d        = grant ? addr1 : addr0;
          data_d       = grant ? data1 : data0;
        end
      end
      ST_SETUP: begin
        state_d  = ST_STROBE;
        en_n_d   = 1'b0;
        strobe_d = 1'b1;
        ack0_d   = ~winner_q;
        ack1_d   = winner_q;
      end
      ST_STROBE: begin
        state_d = ST_RECOVER;
        cnt_d   = cnt_q + 1'b1;
      end
      ST_RECOVER: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      winner_q     <= 1'b0;
      en_n_q       <= 1'b1;
      strobe_q     <= 1'b0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      busy_q       <= 1'b0;
      sel_q        <= '0;
      data_q       <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      winner_q     <= winner_d;
      en_n_q       <= en_n_d;
      strobe_q     <= strobe_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      busy_q       <= busy_d;
      sel_q        <= sel_d;
      data_q       <= data_d;
      cnt_q        <= cnt_d;
    end
  end

  assign ack0          = ack0_q;
  assign ack1          = ack1_q;
  assign dec_en_n      = en_n_q;
  assign dec_wr_strobe = strobe_q;
  assign dec_sel       = sel_q;
  assign dec_data      = data_q;
  assign busy          = busy_q;
  assign wr_count      = cnt_q;

endmodule

// File: tb/tb_port_wr_arb.sv
// Scoreboard bench for port_wr_arb: a transaction-level model predicts each
// committed write; a negedge monitor compares the decoder-side outputs.
module tb_port_wr_arb;

  localparam int ADDR_W = 3;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              req_v [2];
  logic [ADDR_W-1:0] addr_v [2];
  logic [DATA_W-1:0] data_v [2];
  logic              drop_early [2];
  bit                rand_en = 1'b0;
  bit                done = 1'b0;

  logic              req0, req1, ack0, ack1;
  logic [ADDR_W-1:0] addr0, addr1, dec_sel;
  logic [DATA_W-1:0] data0, data1, dec_data;
  logic              dec_en_n, dec_wr_strobe, busy;
  logic [7:0]        wr_count;

  assign req0  = req_v[0];
  assign req1  = req_v[1];
  assign addr0 = addr_v[0];
  assign addr1 = addr_v[1];
  assign data0 = data_v[0];
  assign data1 = data_v[1];

  always #5 clk = ~clk;

  port_wr_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req0          (req0),
    .addr0         (addr0),
    .data0         (data0),
    .ack0          (ack0),
    .req1          (req1),
    .addr1         (addr1),
    .data1         (data1),
    .ack1          (ack1),
    .dec_en_n      (dec_en_n),
    .dec_wr_strobe (dec_wr_strobe),
    .dec_sel       (dec_sel),
    .dec_data      (dec_data),
    .busy          (busy),
    .wr_count      (wr_count)
  );

  typedef struct {
    int                edge_no;
    int                who;
    logic [ADDR_W-1:0] sel;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t exp_q [$];
  int  edge_cnt = 0;
  int  last_g = -100;
  int  prev_winner = 1;
  int  flush_to = 0;
  int  model_winner = 0;
  int  grant_cnt [2] = '{0, 0};
  int  seen_cnt [2] = '{0, 0};
  int  n_checks = 0;
  int  n_pass = 0;

  // Reference model: the arbiter may accept a request at most every 4 edges;
  // the write it accepts strobes one edge later with the data seen at acceptance.
  always @(posedge clk) begin : model
    edge_cnt++;
    if (!reset_n) begin
      last_g      = -100;
      prev_winner = 1;
      flush_to    = exp_q.size();
    end else if ((edge_cnt - last_g >= 4) && (req_v[0] || req_v[1])) begin
      if (req_v[0] && req_v[1]) model_winner = 1 - prev_winner;
      else                      model_winner = req_v[1] ? 1 : 0;
      exp_q.push_back('{edge_no: edge_cnt + 1, who: model_winner,
                        sel: addr_v[model_winner], data: data_v[model_winner]});
      last_g      = edge_cnt;
      prev_winner = model_winner;
      grant_cnt[model_winner]++;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, edge_cnt);
  endtask

  initial begin : monitor
    int         rd_idx;
    int         diff;
    int         pending;
    logic       exp_strobe;
    logic [7:0] exp_wr;
    rd_idx = 0;
    exp_wr = 8'd0;
    while (!done) begin
      @(negedge clk or negedge reset_n);
      if (!reset_n) begin
        #1;
        exp_wr = 8'd0;
        checkOutput("reset_dec_en_n", 32'(dec_en_n), 32'd1);
        checkOutput("reset_strobe", 32'(dec_wr_strobe), 32'd0);
        checkOutput("reset_acks", 32'({ack1, ack0}), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_sel_data", 32'({dec_sel, dec_data}), 32'd0);
        checkOutput("reset_wr_count", 32'(wr_count), 32'd0);
      end else if (!done) begin
        if (rd_idx < flush_to) rd_idx = flush_to;
        while (rd_idx < exp_q.size() && exp_q[rd_idx].edge_no < edge_cnt) rd_idx++;
        exp_strobe = (rd_idx < exp_q.size()) && (exp_q[rd_idx].edge_no == edge_cnt);
        diff = edge_cnt - last_g;
        checkOutput("dec_wr_strobe", 32'(dec_wr_strobe), 32'(exp_strobe));
        checkOutput("dec_en_n", 32'(dec_en_n), (diff <= 1) ? 32'd0 : 32'd1);
        checkOutput("busy", 32'(busy), (diff <= 2) ? 32'd1 : 32'd0);
        checkOutput("wr_count", 32'(wr_count), 32'(exp_wr));
        if (exp_strobe) begin
          checkOutput("dec_sel", 32'(dec_sel), 32'(exp_q[rd_idx].sel));
          checkOutput("dec_data", 32'(dec_data), 32'(exp_q[rd_idx].data));
          checkOutput("ack0", 32'(ack0), (exp_q[rd_idx].who == 0) ? 32'd1 : 32'd0);
          checkOutput("ack1", 32'(ack1), (exp_q[rd_idx].who == 1) ? 32'd1 : 32'd0);
          rd_idx++;
          exp_wr = exp_wr + 8'd1;
        end else begin
          checkOutput("ack_idle", 32'({ack1, ack0}), 32'd0);
        end
      end
    end
    pending = exp_q.size() - ((rd_idx > flush_to) ? rd_idx : flush_to);
    checkOutput("all_writes_committed", 32'(pending), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // One cycle of requester behaviour: release after ack (or right after grant
  // when drop_early is set), and in random mode raise or disturb requests.
  task automatic stepCycle();
    logic ack_i;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      ack_i = (i == 0) ? ack0 : ack1;
      if (req_v[i] && (grant_cnt[i] != seen_cnt[i]) && (drop_early[i] || ack_i)) begin
        req_v[i]    = 1'b0;
        seen_cnt[i] = grant_cnt[i];
      end else if (rand_en && !req_v[i] && ($urandom_range(0, 2) == 0)) begin
        req_v[i]      = 1'b1;
        addr_v[i]     = ADDR_W'($urandom);
        data_v[i]     = DATA_W'($urandom);
        drop_early[i] = ($urandom_range(0, 1) == 1);
      end else if (rand_en && req_v[i] && ($urandom_range(0, 3) == 0)) begin
        addr_v[i] = ADDR_W'($urandom);
        data_v[i] = DATA_W'($urandom);
      end
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) stepCycle();
  endtask

  task automatic applyStimulus(input int who, input logic [ADDR_W-1:0] a,
                               input logic [DATA_W-1:0] d, input logic early);
    req_v[who]      = 1'b1;
    addr_v[who]     = a;
    data_v[who]     = d;
    drop_early[who] = early;
  endtask

  task automatic applyReset();
    #2;
    reset_n  = 1'b0;
    req_v[0] = 1'b0;
    req_v[1] = 1'b0;
    seen_cnt = grant_cnt;
    waitCycles(2);
    #1 reset_n = 1'b1;
  endtask

  initial begin : stimulus
    for (int i = 0; i < 2; i++) begin
      req_v[i]      = 1'b0;
      addr_v[i]     = '0;
      data_v[i]     = '0;
      drop_early[i] = 1'b0;
    end
    $display("[TB] start");
    waitCycles(3);
    #1 reset_n = 1'b1;

    // Single write from requester 0
    applyStimulus(0, 3'b101, 8'hA5, 1'b0);
    waitCycles(8);

    // Simultaneous requests twice, starting from reset tie-break
    applyReset();
    for (int k = 0; k < 2; k++) begin
      applyStimulus(0, 3'd1, 8'h10 + 8'(k), 1'b0);
      applyStimulus(1, 3'd6, 8'h60 + 8'(k), 1'b0);
      waitCycles(10);
    end

    // Data changes after grant must not reach the strobe
    applyStimulus(0, 3'd2, 8'h11, 1'b0);
    stepCycle();
    data_v[0] = 8'h22;
    addr_v[0] = 3'd7;
    waitCycles(6);

    // Requester 0 arrives during requester 1's strobe
    applyStimulus(1, 3'd4, 8'h44, 1'b0);
    waitCycles(2);
    applyStimulus(0, 3'd3, 8'h33, 1'b0);
    waitCycles(10);

    // Reset during SETUP aborts the write
    applyStimulus(0, 3'd3, 8'hC3, 1'b0);
    stepCycle();
    applyReset();
    waitCycles(6);

    // Random traffic long enough to wrap wr_count
    rand_en = 1'b1;
    waitCycles(3000);
    rand_en = 1'b0;
    waitCycles(30);
    done = 1'b1;
  end

endmodule

// File: doc/port_wr_arb.md
PORT_WR_ARB -- requirements
Module: port_wr_arb

Interface
REQ-001 Parameter ADDR_W, default 3, width of port-select field driven to the write decoder.
REQ-002 Parameter DATA_W, default 8, width of output-port write data.
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 req0  input  1  requester 0 (CPU outport path) write request; level, held until ack0.
REQ-006 addr0  input  ADDR_W  requester 0 target port select.
REQ-007 data0  input  DATA_W  requester 0 write data.
REQ-008 ack0  output  1  one-cycle pulse; requester 0 write committed.
REQ-009 req1, addr1, data1, ack1: same as REQ-005..008, requester 1 (config loader).
REQ-010 dec_en_n  output  1  active-low enable to write decoder.
REQ-011 dec_wr_strobe  output  1  active-high write strobe to decoder.
REQ-012 dec_sel  output  ADDR_W  port select to decoder.
REQ-013 dec_data  output  DATA_W  write data to selected port.
REQ-014 busy  output  1  high whenever FSM not in IDLE.
REQ-015 wr_count  output  8  count of committed writes, both requesters.

Function
REQ-016 FSM states: IDLE, SETUP, STROBE, RECOVER; one state per clock.
REQ-017 IDLE: any req high at clock edge -> SETUP; winner's addr/data latched into dec_sel/dec_data at that edge.
REQ-018 SETUP: dec_en_n=0, dec_wr_strobe=0, sel/data stable; -> STROBE unconditionally.
REQ-019 STROBE: dec_en_n=0, dec_wr_strobe=1 exactly one cycle; winner's ack high this same cycle; wr_count increments at end of cycle; -> RECOVER.
REQ-020 RECOVER: dec_en_n=1, dec_wr_strobe=0; -> IDLE unconditionally (one-cycle turnaround, no back-to-back strobes).
REQ-021 Latency: req sampled high at edge N -> strobe and ack during cycle N+2; minimum request spacing 4 cycles.
REQ-022 Arbitration round-robin: sole requester wins; both requesting -> requester not granted last wins; last_grant updates on grant.
REQ-023 Grant is committed once SETUP entered: req drop or addr/data change after grant does not alter or abort the write; ack still pulses.
REQ-024 Requester must deassert req in the cycle after ack; req still high in RECOVER/IDLE is a new request.
REQ-025 Requests arriving during SETUP/STROBE/RECOVER are not lost; evaluated in IDLE.
REQ-026 At most one ack high per cycle; ack never high outside STROBE.
REQ-027 dec_wr_strobe=1 implies dec_en_n=0; dec_en_n=1 in IDLE and RECOVER.
REQ-028 wr_count wraps 255 -> 0 without flag.
REQ-029 All outputs registered; no combinational path from req/addr/data to any output.

Reset
REQ-030 reset_n low: state=IDLE, dec_en_n=1, dec_wr_strobe=0, dec_sel=0, dec_data=0, ack0=ack1=0, busy=0, wr_count=0, last_grant=1 (requester 0 wins first tie).
REQ-031 Reset asserted mid-transaction aborts immediately; no strobe or ack issued for the aborted write; after release, requests resampled from IDLE.

Structure
REQ-032 FSM state encoding and ADDR_W/DATA_W defaults in shared package port_wr_pkg.
REQ-033 Single flat module; round-robin picker may be sub-module rr_pick2 (2-input, last_grant in, grant out, combinational).

Verification
REQ-034 req0=1, addr0=3'b101, data0=8'hA5 in IDLE at edge N -> cycle N+2: dec_wr_strobe=1, dec_sel=5, dec_data=A5, ack0=1; wr_count=1 after.
REQ-035 req0 and req1 rise together twice (addr0=1, addr1=6) -> first strobe sel=1/ack0, second strobe sel=6/ack1, strobes 4 cycles apart.
REQ-036 req1 held, req0 pulsed during req1's STROBE -> req0 served next IDLE; no lost request, no overlapping strobes.
REQ-037 data0 changed from 8'h11 to 8'h22 in SETUP -> strobe carries 8'h11.
REQ-038 reset_n low during SETUP -> no strobe, no ack, dec_en_n=1 immediately; all outputs at reset values.
REQ-039 256 single writes -> wr_count returns to 0; dec_en_n=1 in every RECOVER cycle.
